// File: rtl/rvv_backend_alu_result_arb.sv
// rvv_backend_alu_result_arb: round-robin arbiter sharing the ROB ALU write port between ALU units
package rvv_backend_alu_result_arb_pkg;
   typedef struct packed {
      logic [3:0]  rob_entry;
      logic [31:0] w_data;
      logic        w_valid;
   } PU2ROB_t;
endpackage

module rvv_backend_alu_result_arb
   import rvv_backend_alu_result_arb_pkg::*;
#(
   parameter int NUM_ALU = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_ALU-1:0] alu_result_valid,
   input  PU2ROB_t            alu_result [NUM_ALU],
   output logic [NUM_ALU-1:0] alu_result_ready,
   output logic               rob_result_valid,
   output PU2ROB_t            rob_result,
   input  logic               rob_result_ready,
   input  logic               trap_flush_rvv
);
   localparam int PW = $clog2(NUM_ALU);

   logic          out_valid_q, out_valid_d;
   PU2ROB_t       out_data_q, out_data_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] winner;
   logic          found, load_ok, grant;

   // pick the first valid unit scanning from rr_ptr upward, wrapping modulo NUM_ALU
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_ALU; k++) begin
         for (int i = 0; i < NUM_ALU; i++) begin
            if (!found && alu_result_valid[i] && (i == (int'(rr_ptr_q) + k) % NUM_ALU)) begin
               winner = PW'(i);
               found  = 1'b1;
            end
         end
      end
   end

   // one-hot accept toward the winner; reset and flush suppress every grant
   always_comb begin
      load_ok = rst_n && !trap_flush_rvv && (!out_valid_q || rob_result_ready);
      for (int i = 0; i < NUM_ALU; i++)
         alu_result_ready[i] = load_ok && found && (winner == PW'(i)) && alu_result_valid[i];
      grant = |alu_result_ready;
   end

   // next state: flush beats grant, grant beats drain, otherwise hold
   always_comb begin
      out_valid_d = trap_flush_rvv ? 1'b0 :
                    grant ? 1'b1 :
                    (rob_result_ready && out_valid_q) ? 1'b0 : out_valid_q;
      out_data_d  = grant ? alu_result[winner] : out_data_q;
      rr_ptr_d    = trap_flush_rvv ? '0 :
                    grant ? ((winner == PW'(NUM_ALU - 1)) ? '0 : winner + PW'(1)) : rr_ptr_q;
   end

   // output stage and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign rob_result_valid = out_valid_q;
   assign rob_result       = out_data_q;
endmodule
